// File: rtl/switch_box_pkg.sv
// Shared definitions for the configurable switch box: side indices, select
// encoding, loader FSM states and configuration bit-index helpers.
package switch_box_pkg;

    localparam int unsigned NSIDES     = 4;
    localparam int unsigned SIDE_LEFT  = 0;
    localparam int unsigned SIDE_UP    = 1;
    localparam int unsigned SIDE_RIGHT = 2;
    localparam int unsigned SIDE_DOWN  = 3;

    // A driver whose select is SEL_OFF leaves its track high-Z
    localparam logic [1:0] SEL_OFF = 2'd0;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck,
        StApply
    } cfg_state_e;

    // LSB of the 2-bit select for driver (s, t) in a W-track box
    function automatic int unsigned cfg_idx(input int unsigned w, input int unsigned s,
                                            input int unsigned t);
        return 2 * (s * w + t);
    endfunction

    // Side that feeds side s for a non-zero select; 2-bit add wraps mod 4
    function automatic logic [1:0] src_side(input logic [1:0] s, input logic [1:0] sel);
        return s + sel;
    endfunction

endpackage

// File: rtl/sb_track_loop_check.sv
// Combinational loop detector for one track: flags the track when the
// source graph formed by its four side selects contains a cycle.
module sb_track_loop_check
    import switch_box_pkg::*;
(
    input  logic [2*NSIDES-1:0] i_sels,
    output logic                o_illegal
);

    // Follow source pointers from every side; landing back on the start is a cycle
    always_comb begin : p_walk
        logic [1:0] w_node;
        logic [1:0] w_sel;
        logic       w_live;
        o_illegal = 1'b0;
        w_node    = '0;
        w_sel     = '0;
        w_live    = 1'b0;
        for (int s = 0; s < NSIDES; s++) begin
            w_node = 2'(s);
            w_live = 1'b1;
            for (int k = 0; k < NSIDES; k++) begin
                w_sel = i_sels[2*w_node +: 2];
                if (w_live) begin
                    if (w_sel == SEL_OFF) begin
                        w_live = 1'b0;
                    end else begin
                        w_node = src_side(w_node, w_sel);
                        if (w_node == 2'(s)) begin
                            o_illegal = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/switch_box_cfg.sv
// Four-sided disjoint routing switch box with a chunked configuration loader.
// Words are shifted into a shadow register, each track is checked for
// combinational loops (offending tracks are switched off), then the shadow is
// committed atomically to the active configuration.
// Optional: define SB_REG_OUT_EN to register routed data and enables.
module switch_box_cfg
    import switch_box_pkg::*;
#(
    parameter int unsigned W     = 5,
    parameter int unsigned CFG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [W-1:0]     left,
    inout  wire  [W-1:0]     up,
    inout  wire  [W-1:0]     right,
    inout  wire  [W-1:0]     down,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic [W-1:0]     cfg_err
);

    localparam int unsigned NBITS  = 8 * W;
    localparam int unsigned NWORDS = (NBITS + CFG_W - 1) / CFG_W;
    localparam int unsigned WCW    = $clog2(NWORDS + 1);
    localparam int unsigned TCW    = (W > 1) ? $clog2(W) : 1;

    cfg_state_e          r_state;
    cfg_state_e          w_state_next;
    logic [WCW-1:0]      r_word_cnt;
    logic [WCW-1:0]      w_word_idx;
    logic [TCW-1:0]      r_trk_cnt;
    logic [NBITS-1:0]    r_shadow;
    logic [NBITS-1:0]    r_active;
    logic [NBITS-1:0]    w_shadow_loaded;
    logic [W-1:0]        r_new_err;
    logic [W-1:0]        r_err;
    logic                r_done;
    logic                w_accept;
    logic                w_last_word;
    logic                w_trk_last;
    logic                w_trk_illegal;
    logic [2*NSIDES-1:0] w_trk_sels;

    logic [W-1:0] w_side_in [NSIDES];
    logic [W-1:0] w_drv_en  [NSIDES];
    logic [W-1:0] w_drv_val [NSIDES];
    logic [W-1:0] w_out_en  [NSIDES];
    logic [W-1:0] w_out_val [NSIDES];

    assign w_accept    = cfg_valid && cfg_ready;
    assign w_word_idx  = (r_state == StIdle) ? '0 : r_word_cnt;
    assign w_last_word = (w_word_idx == WCW'(NWORDS - 1));
    assign w_trk_last  = (r_trk_cnt == TCW'(W - 1));

    // Shadow image with the incoming word merged in; bits past NBITS are dropped
    always_comb begin
        w_shadow_loaded = r_shadow;
        for (int b = 0; b < CFG_W; b++) begin
            if (int'(w_word_idx) * CFG_W + b < NBITS) begin
                w_shadow_loaded[int'(w_word_idx) * CFG_W + b] = cfg_data[b];
            end
        end
    end

    // Gather the four side selects of the track under check
    always_comb begin
        w_trk_sels = '0;
        for (int s = 0; s < NSIDES; s++) begin
            w_trk_sels[2*s +: 2] = r_shadow[cfg_idx(W, s, int'(r_trk_cnt)) +: 2];
        end
    end

    sb_track_loop_check u_loop_check (
        .i_sels    (w_trk_sels),
        .o_illegal (w_trk_illegal)
    );

    // Loader FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Loader FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = w_last_word ? StCheck : StLoad;
            StLoad:  if (w_accept && w_last_word) w_state_next = StCheck;
            StCheck: if (w_trk_last) w_state_next = StApply;
            StApply: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Loader FSM outputs
    always_comb begin
        cfg_ready = (r_state == StIdle) || (r_state == StLoad);
        cfg_busy  = (r_state == StCheck) || (r_state == StApply);
        cfg_done  = r_done;
        cfg_err   = r_err;
    end

    // Shadow fill, per-track loop scrub and commit to the active configuration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_cnt <= '0;
            r_trk_cnt  <= '0;
            r_shadow   <= '0;
            r_active   <= '0;
            r_new_err  <= '0;
            r_err      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == StApply);
            case (r_state)
                StIdle, StLoad: begin
                    if (w_accept) begin
                        r_shadow   <= w_shadow_loaded;
                        r_word_cnt <= w_word_idx + 1'b1;
                        if (r_state == StIdle) begin
                            r_new_err <= '0;
                        end
                    end
                end
                StCheck: begin
                    if (w_trk_illegal) begin
                        for (int s = 0; s < NSIDES; s++) begin
                            r_shadow[cfg_idx(W, s, int'(r_trk_cnt)) +: 2] <= SEL_OFF;
                        end
                        r_new_err[r_trk_cnt] <= 1'b1;
                    end
                    r_trk_cnt <= w_trk_last ? '0 : r_trk_cnt + 1'b1;
                end
                StApply: begin
                    r_active   <= r_shadow;
                    r_err      <= r_new_err;
                    r_word_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign w_side_in[SIDE_LEFT]  = left;
    assign w_side_in[SIDE_UP]    = up;
    assign w_side_in[SIDE_RIGHT] = right;
    assign w_side_in[SIDE_DOWN]  = down;

    // Route each driver from its selected source side on the same track
    always_comb begin : p_route
        logic [1:0] w_sel;
        w_sel = SEL_OFF;
        for (int s = 0; s < NSIDES; s++) begin
            w_drv_en[s]  = '0;
            w_drv_val[s] = '0;
            for (int t = 0; t < W; t++) begin
                w_sel           = r_active[cfg_idx(W, s, t) +: 2];
                w_drv_en[s][t]  = (w_sel != SEL_OFF);
                w_drv_val[s][t] = w_side_in[src_side(2'(s), w_sel)][t];
            end
        end
    end

`ifdef SB_REG_OUT_EN
    logic [W-1:0] r_out_en  [NSIDES];
    logic [W-1:0] r_out_val [NSIDES];

    // Register routed data and enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSIDES; s++) begin
                r_out_en[s]  <= '0;
                r_out_val[s] <= '0;
            end
        end else begin
            r_out_en  <= w_drv_en;
            r_out_val <= w_drv_val;
        end
    end

    assign w_out_en  = r_out_en;
    assign w_out_val = r_out_val;
`else
    assign w_out_en  = w_drv_en;
    assign w_out_val = w_drv_val;
`endif

    for (genvar t = 0; t < W; t++) begin : g_track
        assign left[t]  = w_out_en[SIDE_LEFT][t]  ? w_out_val[SIDE_LEFT][t]  : 1'bz;
        assign up[t]    = w_out_en[SIDE_UP][t]    ? w_out_val[SIDE_UP][t]    : 1'bz;
        assign right[t] = w_out_en[SIDE_RIGHT][t] ? w_out_val[SIDE_RIGHT][t] : 1'bz;
        assign down[t]  = w_out_en[SIDE_DOWN][t]  ? w_out_val[SIDE_DOWN][t]  : 1'bz;
    end

endmodule

// File: tb/tb_switch_box_cfg.sv
// Randomised scoreboard bench for switch_box_cfg (W=5, CFG_W=8).
module tb_switch_box_cfg;

    localparam int unsigned W      = 5;
    localparam int unsigned CFG_W  = 8;
    localparam int unsigned NBITS  = 8 * W;
    localparam int unsigned NWORDS = 5;
    localparam int unsigned LAT    = W + 1;

    logic             clk = 1'b0;
    logic             reset;
    wire  [W-1:0]     left, up, right, down;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_busy;
    logic             cfg_done;
    logic [W-1:0]     cfg_err;

    // Bench-side drivers: a track is driven here only where the box leaves it off
    logic [W-1:0] drv_en  [4];
    logic [W-1:0] drv_val [4];

    typedef struct {
        int           exp_cyc;
        logic [W-1:0] exp_err;
    } exp_t;

    exp_t             sb_q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    logic [NBITS-1:0] model_active;
    logic [NBITS-1:0] pending_cfg;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar t = 0; t < W; t++) begin : g_drv
        assign left[t]  = drv_en[0][t] ? drv_val[0][t] : 1'bz;
        assign up[t]    = drv_en[1][t] ? drv_val[1][t] : 1'bz;
        assign right[t] = drv_en[2][t] ? drv_val[2][t] : 1'bz;
        assign down[t]  = drv_en[3][t] ? drv_val[3][t] : 1'bz;
    end

    switch_box_cfg #(
        .W     (W),
        .CFG_W (CFG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .left      (left),
        .up        (up),
        .right     (right),
        .down      (down),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] sel_of(input logic [NBITS-1:0] c, input int s, input int t);
        return c[2*(s*W+t) +: 2];
    endfunction

    function automatic logic [NBITS-1:0] set_sel(input logic [NBITS-1:0] c, input int s,
                                                 input int t, input logic [1:0] v);
        logic [NBITS-1:0] r;
        r = c;
        r[2*(s*W+t) +: 2] = v;
        return r;
    endfunction

    // Four nodes: a 4-step walk that never hits an off driver must revisit a node
    function automatic bit has_loop(input logic [NBITS-1:0] c, input int t);
        for (int st = 0; st < 4; st++) begin
            int node;
            bit live;
            node = st;
            live = 1'b1;
            for (int k = 0; k < 4; k++) begin
                logic [1:0] sl;
                sl = sel_of(c, node, t);
                if (sl == 2'd0) begin
                    live = 1'b0;
                    break;
                end
                node = (node + int'(sl)) % 4;
            end
            if (live) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Value seen on (s,t): follow the source chain to the side the bench drives
    function automatic logic route_val(input int s, input int t);
        int node;
        node = s;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] sl;
            sl = sel_of(model_active, node, t);
            if (sl == 2'd0) return drv_val[node][t];
            node = (node + int'(sl)) % 4;
        end
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] side_rd(input int s);
        case (s)
            0:       return left;
            1:       return up;
            2:       return right;
            default: return down;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (cfg_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_latency", 64'(cyc), 64'(e.exp_cyc));
                    check("cfg_err", 64'(cfg_err), 64'(e.exp_err));
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].exp_cyc) begin
                check("done_timeout", 64'(cyc), 64'(sb_q[0].exp_cyc));
                void'(sb_q.pop_front());
            end
            check("ready_busy_excl", 64'(cfg_ready ^ cfg_busy), 64'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_word(input logic [CFG_W-1:0] d, output int stalls, output int acc_cyc);
        stalls    = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        while (!cfg_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!cfg_ready) check("ready_timeout", 64'd0, 64'd1);
        acc_cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic send_cfg(input logic [NBITS-1:0] c, input int nsend, input bit keep_valid,
                            output int first_stalls);
        int st;
        int ac;
        logic [NBITS-1:0] clean;
        logic [W-1:0] err;
        first_stalls = 0;
        ac = 0;
        for (int i = 0; i < nsend; i++) begin
            if (i > 0 && $urandom_range(0, 2) == 0) begin
                cfg_valid = 1'b0;
                cfg_data  = CFG_W'($urandom);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_word(c[i*CFG_W +: CFG_W], st, ac);
            if (i == 0) first_stalls = st;
        end
        if (nsend == NWORDS) begin
            clean = c;
            err   = '0;
            for (int t = 0; t < W; t++) begin
                if (has_loop(c, t)) begin
                    err[t] = 1'b1;
                    for (int s = 0; s < 4; s++) clean = set_sel(clean, s, t, 2'd0);
                end
            end
            sb_q.push_back('{exp_cyc: ac + LAT, exp_err: err});
            pending_cfg = clean;
        end
        if (!keep_valid) cfg_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("done_wait", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        model_active = pending_cfg;
    endtask

    task automatic check_routing(input string tag);
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < W; t++) begin
                drv_en[s][t]  = (sel_of(model_active, s, t) == 2'd0);
                drv_val[s][t] = 1'($urandom);
            end
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            logic [W-1:0] exp;
            for (int t = 0; t < W; t++) exp[t] = route_val(s, t);
            check(tag, 64'(side_rd(s)), 64'(exp));
        end
    endtask

    function automatic logic [NBITS-1:0] rand_cfg();
        logic [NBITS-1:0] c;
        c = {$urandom, $urandom};
        // Thin out selects so both legal and looping tracks appear
        c = c & {$urandom, $urandom} | ({$urandom, $urandom} & {$urandom, $urandom});
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int st;
        int st2;
        logic [NBITS-1:0] c;
        logic [NBITS-1:0] c2;

        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        for (int s = 0; s < 4; s++) begin
            drv_en[s]  = '1;
            drv_val[s] = W'($urandom);
        end
        model_active = '0;
        pending_cfg  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(cfg_busy), 64'd0);
        check("rst_done", 64'(cfg_done), 64'd0);
        check("rst_err", 64'(cfg_err), 64'd0);
        check_routing("rst_route");

        // Left takes every track from right
        c = '0;
        for (int t = 0; t < W; t++) c = set_sel(c, 0, t, 2'd2);
        send_cfg(c, NWORDS, 1'b0, st);
        wait_done();
        check_routing("tc1_route");
        drv_val[2] = 5'b10110;
        repeat (2) @(negedge clk);
        check("tc1_left", 64'(left), 64'h16);
        check("tc1_err", 64'(cfg_err), 64'd0);

        // Mutual loop on track 2 plus legal up[0] <- down[0]
        c = '0;
        c = set_sel(c, 0, 2, 2'd2);
        c = set_sel(c, 2, 2, 2'd2);
        c = set_sel(c, 1, 0, 2'd2);
        send_cfg(c, NWORDS, 1'b0, st);
        wait_done();
        check("tc2_err", 64'(cfg_err), 64'h04);
        check_routing("tc2_route");

        // Three-cycle loop on track 4, fan-out from up on track 1
        c = '0;
        c = set_sel(c, 0, 4, 2'd1);
        c = set_sel(c, 1, 4, 2'd1);
        c = set_sel(c, 2, 4, 2'd2);
        c = set_sel(c, 0, 1, 2'd1);
        c = set_sel(c, 2, 1, 2'd3);
        send_cfg(c, NWORDS, 1'b0, st);
        wait_done();
        check("tc3_err", 64'(cfg_err), 64'h10);
        check_routing("tc3_route");

        // Reset part-way through a load
        send_cfg(rand_cfg(), 3, 1'b0, st);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_active = '0;
        check("midrst_ready", 64'(cfg_ready), 64'd1);
        check("midrst_busy", 64'(cfg_busy), 64'd0);
        check("midrst_err", 64'(cfg_err), 64'd0);
        check_routing("midrst_route");
        c = '0;
        c[NBITS-1:24] = 16'hA5C3;
        c = set_sel(c, 3, 0, 2'd1);
        send_cfg(c, NWORDS, 1'b0, st);
        wait_done();
        check_routing("post_rst_route");

        // Valid held high through CHECK/APPLY
        c  = rand_cfg();
        c2 = rand_cfg();
        send_cfg(c, NWORDS, 1'b1, st);
        send_cfg(c2, NWORDS, 1'b0, st2);
        check("hold_stalls", 64'(st2), 64'd6);
        wait_done();
        check_routing("hold_route");

        // Random configurations
        for (int n = 0; n < 12; n++) begin
            send_cfg(rand_cfg(), NWORDS, 1'b0, st);
            wait_done();
            check_routing("rand_route");
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
